mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
Parametrised successor to the basic enable counter: an up/down counter with programmable modulus, synchronous clear, parallel load, and wrap or saturate selection. Drives timebases, address generators, and digit counters (e.g. MOD=10 for BCD display digits) in the board designs. Overflow/underflow is reported as a registered event pulse so counters can be cascaded into multi-digit chains.

Parameters:
w, 4, counter width in bits; legal range 1..32.
MOD, 10, modulus; count range 0..MOD-1; legal range 2..2**w.
SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.
PRESCALE, 4, enable-divide ratio (>=1); used only when COUNTER_PRESCALE_EN is defined.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable, sampled each clock
up_dn  input  1  1 = count up, 0 = count down
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  w  value to load
cnt  output  w  current count, registered
tc  output  1  terminal count, combinational: up_dn ? (cnt==MOD-1) : (cnt==0)
ovf  output  1  registered one-cycle event pulse, see Behaviour

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). While rst_n=0: cnt=0, ovf=0, prescaler=0, regardless of clk.
- Priority per edge: clr > load > step.
- clr=1: cnt<=0; ovf<=0.
- load=1 (clr=0):
  - cnt<=load_val if load_val<=MOD-1, else cnt<=MOD-1 (clamp).
  - ovf<=0.
- Step: occurs when clr=0, load=0, en=1 (and, with prescaler, tick=1).
  - Up, cnt<MOD-1: cnt<=cnt+1.
  - Up, cnt==MOD-1: SATURATE=0 gives cnt<=0, ovf<=1. SATURATE=1 holds cnt and sets ovf<=1 (blocked step).
  - Down, cnt>0: cnt<=cnt-1.
  - Down, cnt==0: SATURATE=0 gives cnt<=MOD-1, ovf<=1. SATURATE=1 holds cnt and sets ovf<=1.
  - A step that does not hit a limit gives ovf<=0.
- No step (en=0): cnt holds; ovf<=0.
- ovf is therefore high for exactly one cycle after each limit event. It goes high again on every consecutive blocked step while saturated.
- Latency: cnt and ovf update one clock after the inputs are sampled. tc follows cnt and up_dn combinationally, with zero latency.
- Width rules:
  - All compares are unsigned and done at w bits.
  - MOD-1 is computed as a w-bit constant. When MOD=2**w it equals all-ones, the natural binary wrap.
  - No intermediate value may exceed w bits.
- up_dn may change on any cycle; the new direction applies to the next step.
- Cascading: ovf of digit N feeds en of digit N+1, giving a one-cycle-delayed carry. Alternatively tc&en gives a same-cycle carry.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler of width clog2(PRESCALE) counts en-qualified cycles.
  - tick=1 on the en cycle where prescaler==PRESCALE-1. The prescaler then returns to 0.
  - The main counter steps only when en && tick.
  - clr or load resets the prescaler to 0.
  - PRESCALE=1 gives tick constantly 1.
- Not defined: no prescaler logic, PRESCALE is ignored, and every en cycle is a step.

Test Plan:
- Reset: w=4, MOD=10, assert rst_n=0 mid-count at cnt=7 (asynchronous, between edges) -> cnt=0 and ovf=0 immediately; counting resumes from 0 after release.
- Wrap up: en=1, up_dn=1, 12 cycles from 0 -> cnt 1..9, 0, 1, 2; ovf=1 only in the cycle after 9→0; tc=1 while cnt=9.
- Wrap down: load_val=0, then en=1, up_dn=0 -> cnt 9, 8, 7; ovf pulses after 0→9; tc=1 while cnt=0.
- Saturate: SATURATE=1, count up from 8 for 4 cycles -> cnt 9, 9, 9, 9; ovf=1 for each of the 3 blocked steps.
- Priority and clamp:
  - clr=1, load=1, load_val=5 together -> cnt=0.
  - load=1, load_val=13 -> cnt=9.
  - load=1 with en=1 -> load wins.
- Prescaler (macro defined, PRESCALE=4): en=1 for 8 cycles from 0 -> cnt=2. en toggled 1,0,1,0… for 8 cycles -> cnt=1. Without the macro, the same 8 en cycles -> cnt=8.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down counter with programmable modulus, synchronous
// clear, clamped parallel load, and wrap or saturate at the limits. ovf is a
// registered one-cycle pulse on every limit event, so counters can be cascaded
// into digit chains. tc is the combinational terminal-count flag.
// Optional feature macro: COUNTER_PRESCALE_EN adds an enable prescaler that
// lets the counter step only on every PRESCALE-th enabled cycle.
module mod_updown_counter #(
  parameter int unsigned     w        = 4,
  parameter longint unsigned MOD      = 10,
  parameter int unsigned     SATURATE = 0,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         clr,
  input  logic         load,
  input  logic [w-1:0] load_val,
  output logic [w-1:0] cnt,
  output logic         tc,
  output logic         ovf
);

  // Highest count value as a w-bit constant; MOD=2**w gives all-ones.
  localparam logic [w-1:0] LAST = w'(MOD - 1);

  // Reject illegal parameter sets at elaboration time.
  if (w < 1 || w > 32) begin : g_bad_w
    $error("mod_updown_counter: w must be in 1..32");
  end
  if (MOD < 2 || MOD > (64'd1 << w)) begin : g_bad_mod
    $error("mod_updown_counter: MOD must be in 2..2**w");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be >= 1");
  end

  logic step;

`ifdef COUNTER_PRESCALE_EN
  // A width of at least one bit keeps PRESCALE=1 legal; pre then stays 0.
  localparam int unsigned  PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PLAST);
  assign step = en & tick;

  // Prescaler counts enabled cycles and restarts on tick, clear or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr || load) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end
`else
  assign step = en;
`endif

  // Terminal count looks at the direction the next step would take.
  assign tc = up_dn ? (cnt == LAST) : (cnt == '0);

  // Main count register: clear beats load beats step; ovf marks limit events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= (load_val > LAST) ? LAST : load_val;
      ovf <= 1'b0;
    end else if (step) begin
      if (up_dn) begin
        if (cnt == LAST) begin
          ovf <= 1'b1;
          if (SATURATE == 0) begin
            cnt <= '0;
          end
        end else begin
          cnt <= cnt + 1'b1;
          ovf <= 1'b0;
        end
      end else begin
        if (cnt == '0) begin
          ovf <= 1'b1;
          if (SATURATE == 0) begin
            cnt <= LAST;
          end
        end else begin
          cnt <= cnt - 1'b1;
          ovf <= 1'b0;
        end
      end
    end else begin
      ovf <= 1'b0;
    end
  end

endmodule
